// File: rtl/fft_pkg.sv
// Shared types for the SDF inverse-FFT stage: stage FSM states and a
// default-width complex sample container.
package fft_pkg;

  // Stage FSM states:
  //   EMPTY | delay line being primed, no output yet
  //   FILL  | emitting stored j*(h-x) terms, loading the next frame's first half
  //   BFLY  | butterfly: emit h+x, store j*(h-x)
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    BFLY  = 2'd2
  } sdf_state_t;

  // Default sample width; the stage itself is parameterised and may differ.
  localparam int FFT_DW = 16;

  // Packed complex sample, real part in the upper half.
  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx_t;

endpackage

// File: rtl/sdf_delay_line.sv
// Feedback delay line for the SDF stage: DEPTH-deep shift register that
// advances only when i_en is high. Contents are not reset; the stage never
// lets an unprimed entry reach its outputs.
module sdf_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Shift one entry per accepted step; oldest entry sits at the head.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_head = r_mem[DEPTH-1];

endmodule

// File: rtl/sdf_ifft_stage.sv
// Radix-2 single-delay-feedback inverse-FFT stage with a +j rotation on the
// difference path. Sums leave DELAY steps after their first operand, rotated
// differences 2*DELAY steps after it; outputs are registered (1 clock).
// Build option: define SDF_IFFT_SCALE_EN to halve sums and differences
// (arithmetic shift, truncating); otherwise results wrap to DATA_WIDTH bits.
module sdf_ifft_stage
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DELAY      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         flush,
  input  logic signed [DATA_WIDTH-1:0] real_in,
  input  logic signed [DATA_WIDTH-1:0] imag_in,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] real_out,
  output logic signed [DATA_WIDTH-1:0] imag_out
);

  localparam int CW = (DELAY > 1) ? $clog2(2*DELAY) : 1;
  localparam int AW = DATA_WIDTH + 1;

  sdf_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic w_step, w_flush_step, w_half_end, w_full_end;
  logic signed [DATA_WIDTH-1:0] w_x_re, w_x_im, w_h_re, w_h_im;
  logic [2*DATA_WIDTH-1:0] w_head, w_wr_data;
  logic signed [AW-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im, w_dp_re, w_dp_im;
  logic w_out_en;
  logic signed [DATA_WIDTH-1:0] w_out_re, w_out_im;
  logic r_out_valid;
  logic signed [DATA_WIDTH-1:0] r_out_re, r_out_im;

  // Bring a widened result back to sample width.
  function automatic logic signed [DATA_WIDTH-1:0] reduce(input logic signed [AW-1:0] v);
`ifdef SDF_IFFT_SCALE_EN
    return v[AW-1:1];
`else
    return v[DATA_WIDTH-1:0];
`endif
  endfunction

  // A flush step is a zero sample, valid only while draining in FILL.
  assign w_flush_step = ~in_valid & flush & (r_state == FILL);
  assign w_step       = in_valid | w_flush_step;
  assign w_x_re       = in_valid ? real_in : '0;
  assign w_x_im       = in_valid ? imag_in : '0;
  assign w_half_end   = (r_cnt == CW'(DELAY - 1));
  assign w_full_end   = (r_cnt == CW'(2*DELAY - 1));

  assign w_h_re = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_h_im = w_head[DATA_WIDTH-1:0];

  assign w_sum_re = {w_h_re[DATA_WIDTH-1], w_h_re} + {w_x_re[DATA_WIDTH-1], w_x_re};
  assign w_sum_im = {w_h_im[DATA_WIDTH-1], w_h_im} + {w_x_im[DATA_WIDTH-1], w_x_im};
  assign w_dif_re = {w_h_re[DATA_WIDTH-1], w_h_re} - {w_x_re[DATA_WIDTH-1], w_x_re};
  assign w_dif_im = {w_h_im[DATA_WIDTH-1], w_h_im} - {w_x_im[DATA_WIDTH-1], w_x_im};
  // j*(h-x): the magnitude bound of a difference keeps this negation in range.
  assign w_dp_re  = -w_dif_im;
  assign w_dp_im  = w_dif_re;

  sdf_delay_line #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (DELAY)
  ) u_delay (
    .clk    (clk),
    .i_en   (w_step),
    .i_data (w_wr_data),
    .o_head (w_head)
  );

  // State and sample-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter, delay-line write data and output selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_data   = {w_x_re, w_x_im};
    w_out_en    = 1'b0;
    w_out_re    = w_h_re;
    w_out_im    = w_h_im;
    if (w_step) begin
      w_cnt_nxt = w_full_end ? '0 : r_cnt + 1'b1;
      case (r_state)
        EMPTY: begin
          if (w_half_end) w_state_nxt = BFLY;
        end
        BFLY: begin
          w_out_en  = 1'b1;
          w_out_re  = reduce(w_sum_re);
          w_out_im  = reduce(w_sum_im);
          w_wr_data = {reduce(w_dp_re), reduce(w_dp_im)};
          if (w_full_end) w_state_nxt = FILL;
        end
        FILL: begin
          w_out_en = 1'b1;
          if (w_half_end) begin
            // Draining finished by flush: nothing live remains, restart priming.
            if (w_flush_step) begin
              w_state_nxt = EMPTY;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = BFLY;
            end
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Registered outputs; data holds when no result is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else begin
      r_out_valid <= w_out_en;
      if (w_out_en) begin
        r_out_re <= w_out_re;
        r_out_im <= w_out_im;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign real_out  = r_out_re;
  assign imag_out  = r_out_im;

endmodule

// File: tb/tb_sdf_ifft_stage.sv
// Directed bench for sdf_ifft_stage at DELAY=2, DATA_WIDTH=16. Expected
// values are hand-computed; SDF_IFFT_SCALE_EN picks the scaled set.
module tb_sdf_ifft_stage;

`ifdef SDF_IFFT_SCALE_EN
  localparam bit SCALED = 1'b1;
`else
  localparam bit SCALED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic signed [15:0] real_in = '0;
  logic signed [15:0] imag_in = '0;
  logic out_valid;
  logic signed [15:0] real_out, imag_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit v; bit f; int re; int im;
    bit ev; bit cd; int ere; int eim;
  } vec_t;

  sdf_ifft_stage #(.DATA_WIDTH(16), .DELAY(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
    .real_in(real_in), .imag_in(imag_in),
    .out_valid(out_valid), .real_out(real_out), .imag_out(imag_out)
  );

  always #5 clk = ~clk;

  function automatic int sc(input int unscaled, input int scaled);
    return SCALED ? scaled : unscaled;
  endfunction

  function automatic vec_t mk(input bit v, input bit f, input int re, input int im,
                              input bit ev, input bit cd, input int ere, input int eim);
    vec_t t;
    t.v = v; t.f = f; t.re = re; t.im = im;
    t.ev = ev; t.cd = cd; t.ere = ere; t.eim = eim;
    return t;
  endfunction

  task automatic drive(input bit v, input bit f, input int re, input int im);
    @(negedge clk);
    in_valid = v; flush = f; real_in = 16'(re); imag_in = 16'(im);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || real_out !== 16'sd0 || imag_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_state got v=%0b (%0d,%0d) want v=0 (0,0)", out_valid, real_out, imag_out);
    end
    do_reset();
    drive(0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle out_valid got %0b want 0", out_valid);
    end
  endtask

  task automatic test_basic();
    vec_t q[$];
    do_reset();
    q.push_back(mk(1, 0, 4, 0,   0, 0, 0, 0));
    q.push_back(mk(1, 0, 2, 2,   0, 0, 0, 0));
    q.push_back(mk(1, 0, 1, 0,   1, 0, sc(5, 2), 0));
    q.push_back(mk(1, 0, 0, -2,  1, 0, sc(2, 1), 0));
    q.push_back(mk(0, 1, 0, 0,   1, 0, 0, sc(3, 1)));
    q.push_back(mk(0, 1, 0, 0,   1, 0, sc(-4, -2), sc(2, 1)));
    q.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0));
    // back in EMPTY: two fresh samples only prime the delay line
    q.push_back(mk(1, 0, 7, 7,   0, 0, 0, 0));
    q.push_back(mk(1, 0, 1, 1,   0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i].v, q[i].f, q[i].re, q[i].im);
      checks++;
      if (out_valid !== q[i].ev) begin
        errors++;
        $display("FAIL basic[%0d] out_valid got %0b want %0b", i, out_valid, q[i].ev);
      end
      if (q[i].ev || q[i].cd) begin
        checks++;
        if (real_out !== 16'(q[i].ere) || imag_out !== 16'(q[i].eim)) begin
          errors++;
          $display("FAIL basic[%0d] data got (%0d,%0d) want (%0d,%0d)", i, real_out, imag_out, q[i].ere, q[i].eim);
        end
      end
    end
  endtask

  task automatic test_gap();
    vec_t q[$];
    do_reset();
    q.push_back(mk(1, 0, 4, 0,   0, 0, 0, 0));
    q.push_back(mk(1, 0, 2, 2,   0, 0, 0, 0));
    q.push_back(mk(1, 0, 1, 0,   1, 0, sc(5, 2), 0));
    q.push_back(mk(0, 0, 0, 0,   0, 1, sc(5, 2), 0));
    q.push_back(mk(0, 0, 9, 9,   0, 1, sc(5, 2), 0));
    q.push_back(mk(0, 1, 0, 0,   0, 1, sc(5, 2), 0));
    q.push_back(mk(1, 0, 0, -2,  1, 0, sc(2, 1), 0));
    q.push_back(mk(0, 1, 0, 0,   1, 0, 0, sc(3, 1)));
    q.push_back(mk(0, 1, 0, 0,   1, 0, sc(-4, -2), sc(2, 1)));
    q.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i].v, q[i].f, q[i].re, q[i].im);
      checks++;
      if (out_valid !== q[i].ev) begin
        errors++;
        $display("FAIL gap[%0d] out_valid got %0b want %0b", i, out_valid, q[i].ev);
      end
      if (q[i].ev || q[i].cd) begin
        checks++;
        if (real_out !== 16'(q[i].ere) || imag_out !== 16'(q[i].eim)) begin
          errors++;
          $display("FAIL gap[%0d] data got (%0d,%0d) want (%0d,%0d)", i, real_out, imag_out, q[i].ere, q[i].eim);
        end
      end
    end
  endtask

  task automatic test_wrap();
    vec_t q[$];
    do_reset();
    q.push_back(mk(1, 0, 32767, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 0,     0, 0, 0, 0));
    q.push_back(mk(1, 0, 1, 0,     1, 0, sc(-32768, 16384), 0));
    q.push_back(mk(1, 0, 0, 0,     1, 0, 0, 0));
    q.push_back(mk(0, 1, 0, 0,     1, 0, 0, sc(32766, 16383)));
    q.push_back(mk(0, 1, 0, 0,     1, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i].v, q[i].f, q[i].re, q[i].im);
      checks++;
      if (out_valid !== q[i].ev) begin
        errors++;
        $display("FAIL wrap[%0d] out_valid got %0b want %0b", i, out_valid, q[i].ev);
      end
      if (q[i].ev || q[i].cd) begin
        checks++;
        if (real_out !== 16'(q[i].ere) || imag_out !== 16'(q[i].eim)) begin
          errors++;
          $display("FAIL wrap[%0d] data got (%0d,%0d) want (%0d,%0d)", i, real_out, imag_out, q[i].ere, q[i].eim);
        end
      end
    end
  endtask

  task automatic test_midreset();
    vec_t q[$];
    do_reset();
    drive(1, 0, 4, 0);
    drive(1, 0, 2, 2);
    drive(1, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre out_valid got %0b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || real_out !== 16'sd0 || imag_out !== 16'sd0) begin
      errors++;
      $display("FAIL midreset_async got v=%0b (%0d,%0d) want v=0 (0,0)", out_valid, real_out, imag_out);
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(mk(1, 0, 1, 1,   0, 0, 0, 0));
    q.push_back(mk(1, 0, 3, 0,   0, 0, 0, 0));
    q.push_back(mk(1, 0, 2, -1,  1, 0, sc(3, 1), 0));
    q.push_back(mk(1, 0, 0, 1,   1, 0, sc(3, 1), sc(1, 0)));
    q.push_back(mk(0, 1, 0, 0,   1, 0, sc(-2, -1), -1));
    q.push_back(mk(0, 1, 0, 0,   1, 0, sc(1, 0), sc(3, 1)));
    q.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i].v, q[i].f, q[i].re, q[i].im);
      checks++;
      if (out_valid !== q[i].ev) begin
        errors++;
        $display("FAIL midreset[%0d] out_valid got %0b want %0b", i, out_valid, q[i].ev);
      end
      if (q[i].ev || q[i].cd) begin
        checks++;
        if (real_out !== 16'(q[i].ere) || imag_out !== 16'(q[i].eim)) begin
          errors++;
          $display("FAIL midreset[%0d] data got (%0d,%0d) want (%0d,%0d)", i, real_out, imag_out, q[i].ere, q[i].eim);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t q[$];
    do_reset();
    q.push_back(mk(1, 1, 4, 0,   0, 0, 0, 0));
    q.push_back(mk(1, 1, 2, 2,   0, 0, 0, 0));
    q.push_back(mk(1, 1, 1, 0,   1, 0, sc(5, 2), 0));
    q.push_back(mk(1, 1, 0, -2,  1, 0, sc(2, 1), 0));
    q.push_back(mk(1, 1, 1, 1,   1, 0, 0, sc(3, 1)));
    q.push_back(mk(1, 1, 3, 0,   1, 0, sc(-4, -2), sc(2, 1)));
    q.push_back(mk(1, 1, 2, -1,  1, 0, sc(3, 1), 0));
    q.push_back(mk(1, 1, 0, 1,   1, 0, sc(3, 1), sc(1, 0)));
    q.push_back(mk(0, 1, 0, 0,   1, 0, sc(-2, -1), -1));
    q.push_back(mk(0, 1, 0, 0,   1, 0, sc(1, 0), sc(3, 1)));
    q.push_back(mk(0, 1, 0, 0,   0, 0, 0, 0));
    q.push_back(mk(0, 1, 0, 0,   0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i].v, q[i].f, q[i].re, q[i].im);
      checks++;
      if (out_valid !== q[i].ev) begin
        errors++;
        $display("FAIL b2b[%0d] out_valid got %0b want %0b", i, out_valid, q[i].ev);
      end
      if (q[i].ev || q[i].cd) begin
        checks++;
        if (real_out !== 16'(q[i].ere) || imag_out !== 16'(q[i].eim)) begin
          errors++;
          $display("FAIL b2b[%0d] data got (%0d,%0d) want (%0d,%0d)", i, real_out, imag_out, q[i].ere, q[i].eim);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_wrap();
    test_midreset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
